usb_token_tx: RTL and testbench

Transmit-side counterpart of the CRC5 token checker. Serializes one USB token packet, sending the PID byte, the 11-bit address/endpoint field and the generated CRC5. Output is an unencoded bit stream with bit stuffing applied. Sits between the host/device protocol controller and the NRZI/SYNC/EOP line encoder, paced by a bit-rate strobe from the transceiver clock domain logic.

---
 rtl/usb_pkg.sv | 34 +++
 rtl/usb_crc5_serial.sv | 29 ++
 rtl/usb_token_tx.sv | 126 ++++++++++++
 tb/tb_usb_token_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB token definitions: PID codes, CRC5 constants and the token
// transmitter state type.
package usb_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_SOF   = 4'b0101;

   localparam logic [4:0] CRC5_POLY = 5'b00101;
   localparam logic [4:0] CRC5_INIT = 5'b11111;

   localparam int unsigned PID_BITS  = 8;
   localparam int unsigned DATA_BITS = 11;
   localparam int unsigned CRC_BITS  = 5;
   localparam int unsigned CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      PID,
      DATA,
      CRC
   } tx_state_e;

   // Index of the last bit of the field transmitted in state s.
   function automatic logic [CNT_W-1:0] field_last(input tx_state_e s);
      case (s)
         PID:     return CNT_W'(PID_BITS - 1);
         DATA:    return CNT_W'(DATA_BITS - 1);
         default: return CNT_W'(CRC_BITS - 1);
      endcase
   endfunction

endpackage

// File: rtl/usb_crc5_serial.sv
// Bit-serial CRC5 (x^5 + x^2 + 1) engine; crc_c presents the inverted remainder.
module usb_crc5_serial
   import usb_pkg::*;
#(
   parameter logic [4:0] INIT = CRC5_INIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [4:0] crc_c
);

   logic [4:0] r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r <= INIT;
      end else if (clr) begin
         r <= INIT;
      end else if (en) begin
         r <= {r[3:0], 1'b0} ^ (((din ^ r[4]) == 1'b1) ? CRC5_POLY : 5'b00000);
      end
   end

   assign crc_c = ~r;

endmodule

// File: rtl/usb_token_tx.sv
// USB token packet serializer: PID byte, 11-bit token field and CRC5, with
// bit stuffing, one bit per bit_en strobe.
module usb_token_tx
   import usb_pkg::*;
#(
   parameter int unsigned STUFF_LEN = 6,
   parameter logic [4:0]  CRC_INIT  = 5'b11111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bit_en,
   input  logic        start,
   input  logic [3:0]  pid,
   input  logic [10:0] d,
   output logic        busy,
   output logic        tx_bit,
   output logic        tx_valid,
   output logic        done,
   output logic [4:0]  crc5
);

   localparam int unsigned OW = $clog2(STUFF_LEN + 1);

   tx_state_e        state;
   logic [7:0]       pid_byte;
   logic [10:0]      d_r;
   logic [CNT_W-1:0] cnt;
   logic [OW-1:0]    ones;

   logic             stuff_c;
   logic             bit_c;
   logic             accept_c;
   logic             crc_en_c;
   logic [4:0]       crc_c;

   assign stuff_c  = (ones == OW'(STUFF_LEN));
   assign accept_c = (state == IDLE) && start;
   assign crc_en_c = bit_en && (state == DATA) && !stuff_c;

   // Next field bit to send when no stuff bit is due.
   always_comb begin
      bit_c = 1'b0;
      case (state)
         PID:     bit_c = pid_byte[cnt[2:0]];
         DATA:    bit_c = d_r[cnt];
         CRC:     if (cnt < CNT_W'(CRC_BITS)) bit_c = crc_c[3'(CNT_W'(CRC_BITS - 1) - cnt)];
         default: bit_c = 1'b0;
      endcase
   end

   usb_crc5_serial #(
      .INIT (CRC_INIT)
   ) u_crc (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept_c),
      .en    (crc_en_c),
      .din   (bit_c),
      .crc_c (crc_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pid_byte <= 8'h00;
         d_r      <= 11'h000;
         cnt      <= '0;
         ones     <= '0;
         busy     <= 1'b0;
         tx_bit   <= 1'b0;
         tx_valid <= 1'b0;
         done     <= 1'b0;
         crc5     <= 5'b00000;
      end else begin
         tx_valid <= 1'b0;
         done     <= 1'b0;
         // The remainder is final once DATA completes and stays put through CRC.
         if (state == CRC) crc5 <= crc_c;

         if (state == IDLE) begin
            if (start) begin
               pid_byte <= {~pid, pid};
               d_r      <= d;
               cnt      <= '0;
               ones     <= '0;
               busy     <= 1'b1;
               state    <= PID;
            end
         end else if (bit_en) begin
            tx_valid <= 1'b1;
            if (stuff_c) begin
               tx_bit <= 1'b0;
               ones   <= '0;
               // cnt parked past the last CRC bit marks the trailing stuff slot.
               if (state == CRC && cnt == CNT_W'(CRC_BITS)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end else begin
               tx_bit <= bit_c;
               ones   <= bit_c ? OW'(ones + 1'b1) : '0;
               if (cnt == field_last(state)) begin
                  cnt <= '0;
                  case (state)
                     PID:  state <= DATA;
                     DATA: state <= CRC;
                     default: begin
                        if (bit_c && ones == OW'(STUFF_LEN - 1)) begin
                           cnt <= CNT_W'(CRC_BITS);
                        end else begin
                           done  <= 1'b1;
                           busy  <= 1'b0;
                           state <= IDLE;
                        end
                     end
                  endcase
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_token_tx.sv
// Randomized scoreboard bench for usb_token_tx against a packet-level model.
module tb_usb_token_tx;
   import usb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        bit_en;
   logic        start;
   logic [3:0]  pid;
   logic [10:0] d;
   logic        busy;
   logic        tx_bit;
   logic        tx_valid;
   logic        done;
   logic [4:0]  crc5;

   int          total = 0;
   int          bad = 0;
   bit          exp_q[$];
   logic [4:0]  crc_q[$];
   int          done_cnt = 0;
   int          bits_seen = 0;
   int          en_mode = 0;
   int          cyc = 0;
   logic        prev_en = 1'b0;

   usb_token_tx dut (
      .clk      (clk),
      .rst      (rst),
      .bit_en   (bit_en),
      .start    (start),
      .pid      (pid),
      .d        (d),
      .busy     (busy),
      .tx_bit   (tx_bit),
      .tx_valid (tx_valid),
      .done     (done),
      .crc5     (crc5)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: CRC over the token field, then field concatenation and stuffing.
   function automatic logic [4:0] ref_crc(input logic [10:0] dd);
      int r = 31;
      for (int i = 0; i < 11; i++) begin
         int fb = dd[i] ^ ((r >> 4) & 1);
         r = ((r << 1) & 31) ^ (fb != 0 ? 5 : 0);
      end
      return 5'(~r);
   endfunction

   task automatic push_packet(input logic [3:0] p, input logic [10:0] dd);
      bit          raw[$];
      logic [7:0]  pb = {~p, p};
      logic [4:0]  c = ref_crc(dd);
      int          run = 0;
      for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
      for (int i = 0; i < 11; i++) raw.push_back(dd[i]);
      for (int i = 4; i >= 0; i--) raw.push_back(c[i]);
      foreach (raw[i]) begin
         exp_q.push_back(raw[i]);
         run = raw[i] ? run + 1 : 0;
         if (run == 6) begin
            exp_q.push_back(1'b0);
            run = 0;
         end
      end
      crc_q.push_back(c);
   endtask

   // bit_en pattern generator
   always @(posedge clk) begin
      #1;
      cyc++;
      case (en_mode)
         0:       bit_en = 1'b1;
         1:       bit_en = (cyc % 4 == 0);
         default: bit_en = ($urandom_range(0, 2) == 0);
      endcase
   end

   // Monitor: pops the scoreboard on every tx_valid.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_valid) begin
            check("valid_after_en", 32'(prev_en), 32'd1);
            bits_seen++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_bit: got tx_valid=1 want no output (t=%0t)", $time);
            end else begin
               check("tx_bit", 32'(tx_bit), 32'(exp_q.pop_front()));
               check("done_flag", 32'(done), 32'(exp_q.size() == 0));
               if (exp_q.size() == 0 && crc_q.size() != 0) begin
                  check("crc5", 32'(crc5), 32'(crc_q.pop_front()));
                  check("busy_at_done", 32'(busy), 32'd0);
               end
            end
         end else begin
            check("stray_done", 32'(done), 32'd0);
         end
         if (done) done_cnt++;
      end
      prev_en = bit_en;
   end

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!done && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic send(input logic [3:0] p, input logic [10:0] dd, input bit wait_for_done);
      wait_idle();
      pid   = p;
      d     = dd;
      start = 1'b1;
      @(posedge clk); #1;
      push_packet(p, dd);
      bits_seen = 0;
      check("busy_after_accept", 32'(busy), 32'd1);
      start = 1'b0;
      pid   = 4'($urandom);
      d     = 11'($urandom);
      if (wait_for_done) wait_done();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc0;
      int t;
      logic [3:0] pids[4];
      pids[0] = PID_OUT; pids[1] = PID_IN; pids[2] = PID_SETUP; pids[3] = PID_SOF;
      rst = 1'b1; bit_en = 1'b0; start = 1'b0; pid = 4'h0; d = 11'h000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_crc5", 32'(crc5), 32'd0);
      check("rst_bit", 32'(tx_bit), 32'd0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      en_mode = 0;
      send(PID_OUT,   {4'hE, 7'h15}, 1'b1);
      send(PID_SETUP, 11'h000,       1'b1);
      send(PID_OUT,   11'h7FF,       1'b1);
      en_mode = 1;
      send(PID_OUT,   {4'hA, 7'h3A}, 1'b1);

      // Start pulses while busy must be ignored.
      en_mode = 0;
      send(PID_IN, 11'h5A3, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1; pid = PID_SOF; d = 11'h123;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      // Back-to-back: start immediately following done.
      send(PID_SETUP, 11'h7F0, 1'b1);
      send(PID_IN,    11'h3FF, 1'b1);

      // Reset at bit 12 aborts with no done pulse.
      send(PID_OUT, 11'h4C7, 1'b0);
      t = 0;
      while (bits_seen < 12 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("reached_bit12", 32'(bits_seen >= 12), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(tx_valid), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_crc5", 32'(crc5), 32'd0);
      check("abort_bit", 32'(tx_bit), 32'd0);
      exp_q.delete();
      crc_q.delete();
      dc0 = done_cnt;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'(dc0));
      send(PID_OUT, 11'h4C7, 1'b1);

      // Randomized packets with varying bit_en pacing.
      for (int i = 0; i < 24; i++) begin
         en_mode = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0)
            send(4'($urandom), 11'($urandom), 1'b1);
         else
            send(pids[$urandom_range(0, 3)], 11'($urandom), 1'b1);
      end

      repeat (20) @(posedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_busy", 32'(busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
